mem_responder: RTL

Memory-side responder for the request-unit handshake. It answers the pipeline's iREN/dREN/dWEN requests with one-cycle ihit/dhit pulses and returned load data. It arbitrates instruction and data traffic onto a single-ported RAM, and data requests take priority. It sits between the request unit/datapath and the RAM model.

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/mem_responder_if.sv | 22 ++
 rtl/access_timer.sv | 32 +++
 rtl/mem_responder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory responder slice.
//   ramstate_t      : status reported by the RAM model
//   memresp_state_t : responder FSM states
//   word_t          : native 32-bit data word
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DACC  = 3'd1,
        IACC  = 3'd2,
        DDONE = 3'd3,
        IDONE = 3'd4
    } memresp_state_t;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request-unit-facing bundle of the memory responder.
//   resp modport: responder side (takes requests, returns hits/load data).
interface mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] iaddr;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              ihit;
    logic              dhit;
    logic [DATA_W-1:0] iload;
    logic [DATA_W-1:0] dload;

    modport resp (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore,
        output ihit, dhit, iload, dload
    );
endinterface

// File: rtl/access_timer.sv
// Wait-cycle bound for one RAM access.
//   CLK, RST : clock, async active-high reset
//   clr      : reload the bound (held while no access is in progress)
//   en       : count this cycle as a wait cycle
//   expired  : this enabled cycle is the TIMEOUT-th wait cycle
module access_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= CW'(TIMEOUT);
        end else if (clr) begin
            cnt <= CW'(TIMEOUT);
        end else if (en && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Terminal count: the last remaining wait cycle is being consumed now.
    assign expired = en && (cnt == CW'(1));

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates instruction/data requests onto a
// single-ported RAM (data first) and answers with one-cycle hit pulses.
//   CLK, RST                 : clock, async active-high reset
//   iREN/iaddr               : instruction fetch request
//   dREN/dWEN/daddr/dstore   : data read/write request
//   ihit/iload, dhit/dload   : completion pulses and registered load data
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate : RAM side
//   merr                     : sticky error flag
//
// state | meaning
// IDLE  | sample requests, data beats instruction
// DACC  | data access on RAM, waits for ACCESS/ERROR/timeout
// IACC  | instruction fetch on RAM, aborts on flush
// DDONE | dhit pulse
// IDONE | ihit pulse
module mem_responder
    import cpu_types_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              ihit,
    output logic              dhit,
    output logic [DATA_W-1:0] iload,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  ramstate_t         ramstate,
    output logic              merr
);
    memresp_state_t    state, next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] store_q;
    logic              op_write_q;
    logic [DATA_W-1:0] iload_q, dload_q;
    logic              merr_q;

    logic in_acc, tmr_en, tmr_expired, fail, iabort, got_access;

    assign in_acc     = (state == DACC) || (state == IACC);
    assign got_access = (ramstate == ACCESS);
    assign tmr_en     = in_acc && !got_access;
    // Forced completion: RAM reported an error or the wait bound ran out.
    assign fail       = in_acc && !got_access && ((ramstate == ERROR) || tmr_expired);
    // Fetch is flushed when the pipeline withdraws or redirects the request.
    assign iabort     = (state == IACC) && (!iREN || (iaddr != addr_q));

    access_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (!in_acc),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            addr_q     <= '0;
            store_q    <= '0;
            op_write_q <= 1'b0;
            iload_q    <= '0;
            dload_q    <= '0;
            merr_q     <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (dWEN) begin
                        addr_q     <= daddr;
                        store_q    <= dstore;
                        op_write_q <= 1'b1;
                        if (dREN) merr_q <= 1'b1;
                    end else if (dREN) begin
                        addr_q     <= daddr;
                        op_write_q <= 1'b0;
                    end else if (iREN) begin
                        addr_q <= iaddr;
                    end
                end
                DACC: begin
                    if (got_access) begin
                        if (!op_write_q) dload_q <= ramload;
                    end else if (fail) begin
                        merr_q <= 1'b1;
                        if (!op_write_q) dload_q <= ERR_WORD;
                    end
                end
                IACC: begin
                    if (!iabort) begin
                        if (got_access) begin
                            iload_q <= ramload;
                        end else if (fail) begin
                            merr_q  <= 1'b1;
                            iload_q <= ERR_WORD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        dhit       = 1'b0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        case (state)
            IDLE: begin
                if (dWEN || dREN) next_state = DACC;
                else if (iREN)    next_state = IACC;
            end
            DACC: begin
                ramREN   = !op_write_q;
                ramWEN   = op_write_q;
                ramaddr  = addr_q;
                ramstore = op_write_q ? store_q : '0;
                if (got_access || fail) next_state = DDONE;
            end
            IACC: begin
                ramREN  = 1'b1;
                ramaddr = addr_q;
                if (iabort)                  next_state = IDLE;
                else if (got_access || fail) next_state = IDONE;
            end
            DDONE: begin
                dhit       = 1'b1;
                next_state = IDLE;
            end
            IDONE: begin
                ihit       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign iload = iload_q;
    assign dload = dload_q;
    assign merr  = merr_q;

endmodule
